operand_fwd_stage: RTL and testbench
====================================

Name: operand_fwd_stage

Overview:
- Parametrised successor to the EXE-stage operand-select mux.
- Resolves NUM_SRC source operands per instruction with priority: immediate, x0, MEM-stage ALU result, WB write data, register-file data.
- Detects load-use hazards. On a hit it stalls ID in a small FSM until the D-cache returns extended load data, then injects that data.
- Presents registered operands to EXE over a valid/ready handshake, and keeps a saturating count of load-stall cycles.

Parameters:
DATA_W, 32, operand width in bits
NUM_SRC, 2, number of source operands per instruction
REG_AW, 5, register address width
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
id_valid  input  1  ID has an instruction to issue
id_ready  output  1  block accepts the ID instruction this cycle
id_rs_addr  input  NUM_SRC*REG_AW  source register addresses; slice i is source i
id_rf_data  input  NUM_SRC*DATA_W  register-file read data per source
id_imm  input  DATA_W  immediate value
id_imm_sel  input  NUM_SRC  bit i set: source i takes id_imm
mem_wr_en  input  1  MEM-stage instruction writes rd
mem_rd_addr  input  REG_AW  MEM-stage destination register
mem_is_load  input  1  MEM-stage instruction is a load
mem_alu_result  input  DATA_W  MEM-stage ALU result
wb_wr_en  input  1  WB-stage write enable
wb_rd_addr  input  REG_AW  WB-stage destination register
wb_data  input  DATA_W  WB-stage write data
ld_valid  input  1  D-cache load data valid
ld_data  input  DATA_W  extended D-cache load data
exe_valid  output  1  exe_src holds valid operands
exe_ready  input  1  EXE consumes operands this cycle
exe_src  output  NUM_SRC*DATA_W  registered operands
stall_cycles  output  CNT_W  saturating count of WAIT_LD cycles

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE; exe_valid=0; exe_src=0; pending mask=0; stall_cycles=0.
  - Reset overrides all other events, including mid-WAIT_LD; the in-flight instruction is dropped.
- id_ready = (state==IDLE) && (!exe_valid || exe_ready). This is combinational. Accept occurs when id_valid && id_ready.
- Per-source select at accept, first match wins:
  1. id_imm_sel[i]=1 → id_imm.
  2. rs_addr==0 → 0.
  3. mem_wr_en && mem_rd_addr==rs_addr && mem_rd_addr!=0:
     - mem_is_load=0 → mem_alu_result.
     - mem_is_load=1 → set pending[i].
  4. wb_wr_en && wb_rd_addr==rs_addr && wb_rd_addr!=0 → wb_data.
  5. Otherwise → id_rf_data slice i.
- MEM beats WB when both match the same register. Registers are never forwarded to x0.
- FSM states: IDLE, WAIT_LD.
  - IDLE, accept with pending==0: exe_src ← selected values; exe_valid←1 next cycle. One-cycle latency.
  - IDLE, accept with pending!=0:
    - Non-pending sources are captured into exe_src; pending sources are left unchanged.
    - exe_valid←0; state→WAIT_LD.
  - IDLE, exe_ready && exe_valid && no accept: exe_valid←0.
  - WAIT_LD, ld_valid=1: every pending source ← ld_data; pending←0; exe_valid←1; state→IDLE.
  - WAIT_LD, ld_valid=0: hold. stall_cycles increments, saturating at 2^CNT_W−1 with no wrap.
  - ld_valid in IDLE is ignored.
  - id_ready=0 throughout WAIT_LD; the ID inputs are don't-care there.
- Output hold: while exe_valid=1 && exe_ready=0, exe_src and exe_valid stay stable.
- Back-to-back: a new instruction is accepted in the same cycle EXE consumes the current one (exe_valid && exe_ready && accept), giving full throughput.
- Width rules:
  - Slice i of every packed bus is [i*W +: W].
  - All data paths are DATA_W wide with no extension inside the block; ld_data arrives already extended.

Test Plan:
- Reset: assert rst for 2 cycles with id_valid=1 → exe_valid=0, exe_src=0, stall_cycles=0, id_ready=1 after release.
- Priority:
  - Stimulus: rs=5 for both sources; mem_wr_en=1, mem_rd_addr=5, mem_alu_result=0xAAAA0000; wb_wr_en=1, wb_rd_addr=5, wb_data=0x5555; id_imm_sel=2'b10, id_imm=0x10.
  - Response: next cycle exe_src[0]=0xAAAA0000, exe_src[1]=0x10.
  - Repeat with rs=0 and all forwards targeting register 0 → source reads 0.
- Load-use:
  - Stimulus: rs0=7, mem_is_load=1, mem_rd_addr=7; rs1 from rf=0x1234; ld_valid held low for 3 cycles, then ld_data=0xDEADBEEF.
  - Response: id_ready=0 for 3 cycles; then exe_valid=1, exe_src[0]=0xDEADBEEF, exe_src[1]=0x1234; stall_cycles=3.
- Backpressure: exe_ready=0 for 4 cycles after a valid issue → exe_src unchanged and id_ready=0. When exe_ready rises, a queued ID instruction is accepted the same cycle and its operands appear on the next cycle.
- Reset mid-WAIT_LD: enter WAIT_LD, assert rst, then pulse ld_valid → state IDLE, exe_valid remains 0, stall_cycles=0.
- Saturation: CNT_W=4, hold WAIT_LD for 20 cycles → stall_cycles=15 and stays 15.

Source files
------------

// File: rtl/operand_fwd_stage.sv
// EXE-stage operand select with MEM/WB forwarding, load-use stall FSM and a
// valid/ready output register carrying NUM_SRC operands.
module operand_fwd_stage #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  output logic                        id_ready,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs_addr,
  input  logic [NUM_SRC*DATA_W-1:0]   id_rf_data,
  input  logic [DATA_W-1:0]           id_imm,
  input  logic [NUM_SRC-1:0]          id_imm_sel,
  input  logic                        mem_wr_en,
  input  logic [REG_AW-1:0]           mem_rd_addr,
  input  logic                        mem_is_load,
  input  logic [DATA_W-1:0]           mem_alu_result,
  input  logic                        wb_wr_en,
  input  logic [REG_AW-1:0]           wb_rd_addr,
  input  logic [DATA_W-1:0]           wb_data,
  input  logic                        ld_valid,
  input  logic [DATA_W-1:0]           ld_data,
  output logic                        exe_valid,
  input  logic                        exe_ready,
  output logic [NUM_SRC*DATA_W-1:0]   exe_src,
  output logic [CNT_W-1:0]            stall_cycles
);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } state_t;

  state_t                      state, state_nxt;
  logic                        valid_nxt;
  logic [NUM_SRC*DATA_W-1:0]   src_nxt;
  logic [NUM_SRC-1:0]          pending, pend_nxt;
  logic [CNT_W-1:0]            cnt_nxt;
  logic [NUM_SRC*DATA_W-1:0]   sel_data;
  logic [NUM_SRC-1:0]          sel_pend;
  logic                        accept;

  assign id_ready = (state == IDLE) && (!exe_valid || exe_ready);
  assign accept   = id_valid && id_ready;

  // Per-source priority select; a MEM-stage load match marks the source
  // pending instead of producing data.
  always_comb begin
    logic [REG_AW-1:0] rs;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    sel_data = id_rf_data;
    sel_pend = '0;
    rs       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs = id_rs_addr[i*REG_AW +: REG_AW];
      if (id_imm_sel[i]) begin
        sel_data[i*DATA_W +: DATA_W] = id_imm;
      end else if (rs == '0) begin
        sel_data[i*DATA_W +: DATA_W] = '0;
      end else if (mem_wr_en && mem_rd_addr == rs && mem_rd_addr != '0) begin
        sel_data[i*DATA_W +: DATA_W] = mem_alu_result;
        sel_pend[i]                  = mem_is_load;
      end else if (wb_wr_en && wb_rd_addr == rs && wb_rd_addr != '0) begin
        sel_data[i*DATA_W +: DATA_W] = wb_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = exe_valid;
    src_nxt   = exe_src;
    pend_nxt  = pending;
    cnt_nxt   = stall_cycles;
    case (state)
      IDLE: begin
        if (accept) begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (!sel_pend[i]) src_nxt[i*DATA_W +: DATA_W] = sel_data[i*DATA_W +: DATA_W];
          end
          pend_nxt = sel_pend;
          if (|sel_pend) begin
            valid_nxt = 1'b0;
            state_nxt = WAIT_LD;
          end else begin
            valid_nxt = 1'b1;
          end
        end else if (exe_valid && exe_ready) begin
          valid_nxt = 1'b0;
        end
      end
      WAIT_LD: begin
        if (ld_valid) begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i]) src_nxt[i*DATA_W +: DATA_W] = ld_data;
          end
          pend_nxt  = '0;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (stall_cycles != {CNT_W{1'b1}}) begin
          cnt_nxt = stall_cycles + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples the values from before the edge; combinational blocks use blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      exe_valid    <= 1'b0;
      exe_src      <= '0;
      pending      <= '0;
      stall_cycles <= '0;
    end else begin
      state        <= state_nxt;
      exe_valid    <= valid_nxt;
      exe_src      <= src_nxt;
      pending      <= pend_nxt;
      stall_cycles <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Self-checking bench for operand_fwd_stage: directed vector table, load-use,
// backpressure and saturation sequences, then random traffic against a model.
module tb_operand_fwd_stage;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                        clk;
  logic                        rst;
  logic                        id_valid;
  logic                        id_ready;
  logic [NUM_SRC*REG_AW-1:0]   id_rs_addr;
  logic [NUM_SRC*DATA_W-1:0]   id_rf_data;
  logic [DATA_W-1:0]           id_imm;
  logic [NUM_SRC-1:0]          id_imm_sel;
  logic                        mem_wr_en;
  logic [REG_AW-1:0]           mem_rd_addr;
  logic                        mem_is_load;
  logic [DATA_W-1:0]           mem_alu_result;
  logic                        wb_wr_en;
  logic [REG_AW-1:0]           wb_rd_addr;
  logic [DATA_W-1:0]           wb_data;
  logic                        ld_valid;
  logic [DATA_W-1:0]           ld_data;
  logic                        exe_valid;
  logic                        exe_ready;
  logic [NUM_SRC*DATA_W-1:0]   exe_src;
  logic [CNT_W-1:0]            stall_cycles;

  logic [REG_AW-1:0] rs_a [NUM_SRC];
  logic [DATA_W-1:0] rf_a [NUM_SRC];

  always_comb begin
    id_rs_addr = '0;
    id_rf_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_rs_addr[i*REG_AW +: REG_AW] = rs_a[i];
      id_rf_data[i*DATA_W +: DATA_W] = rf_a[i];
    end
  end

  operand_fwd_stage #(
    .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs_addr(id_rs_addr), .id_rf_data(id_rf_data),
    .id_imm(id_imm), .id_imm_sel(id_imm_sel),
    .mem_wr_en(mem_wr_en), .mem_rd_addr(mem_rd_addr), .mem_is_load(mem_is_load),
    .mem_alu_result(mem_alu_result),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_src(exe_src),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] src(input int i);
    return exe_src[i*DATA_W +: DATA_W];
  endfunction

  // Reference model: one waiting flag, an output slot per source, a per-source
  // "waiting for load data" flag and an integer stall counter.
  bit              m_wait;
  bit              m_valid;
  logic [DATA_W-1:0] m_src [NUM_SRC];
  bit              m_pend [NUM_SRC];
  int              m_cnt;

  // Newest producer of a register wins: MEM is younger than WB, which is
  // younger than the register file; x0 is hardwired and the immediate overrides all.
  function automatic void model_pick(input int i, output logic [DATA_W-1:0] d, output bit p);
    p = 0;
    d = rf_a[i];
    if (id_imm_sel[i])                          d = id_imm;
    else if (rs_a[i] == 0)                      d = '0;
    else if (mem_wr_en && mem_rd_addr == rs_a[i]) begin
      if (mem_is_load) p = 1;
      else             d = mem_alu_result;
    end
    else if (wb_wr_en && wb_rd_addr == rs_a[i]) d = wb_data;
  endfunction

  task automatic model_step();
    logic [DATA_W-1:0] d [NUM_SRC];
    bit                p [NUM_SRC];
    bit                any_p;
    if (rst) begin
      m_wait = 0; m_valid = 0; m_cnt = 0;
      for (int i = 0; i < NUM_SRC; i++) begin m_src[i] = '0; m_pend[i] = 0; end
    end else if (!m_wait) begin
      if (id_valid && (!m_valid || exe_ready)) begin
        any_p = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
          model_pick(i, d[i], p[i]);
          any_p |= p[i];
        end
        for (int i = 0; i < NUM_SRC; i++) begin
          if (!p[i]) m_src[i] = d[i];
          m_pend[i] = p[i];
        end
        m_valid = !any_p;
        m_wait  = any_p;
      end else if (m_valid && exe_ready) begin
        m_valid = 0;
      end
    end else if (ld_valid) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (m_pend[i]) m_src[i] = ld_data;
        m_pend[i] = 0;
      end
      m_valid = 1;
      m_wait  = 0;
    end else if (m_cnt < CNT_MAX) begin
      m_cnt++;
    end
  endtask

  // One clock: check the combinational ready, advance the model, then compare
  // the registered outputs shortly after the edge.
  task automatic cycle();
    #1;
    if (!rst) check("id_ready", id_ready, !m_wait && (!m_valid || exe_ready));
    model_step();
    @(posedge clk);
    #1;
    check("exe_valid", exe_valid, m_valid);
    for (int i = 0; i < NUM_SRC; i++) check($sformatf("exe_src%0d", i), src(i), m_src[i]);
    check("stall_cycles", stall_cycles, m_cnt);
  endtask

  task automatic idle_inputs();
    rst = 0; id_valid = 0; id_imm = '0; id_imm_sel = '0;
    mem_wr_en = 0; mem_rd_addr = '0; mem_is_load = 0; mem_alu_result = '0;
    wb_wr_en = 0; wb_rd_addr = '0; wb_data = '0;
    ld_valid = 0; ld_data = '0; exe_ready = 1;
    for (int i = 0; i < NUM_SRC; i++) begin rs_a[i] = '0; rf_a[i] = '0; end
  endtask

  task automatic issue_load_use(input logic [REG_AW-1:0] r);
    idle_inputs();
    id_valid = 1; rs_a[0] = r; rs_a[1] = 5'd2; rf_a[1] = 32'h1234;
    mem_wr_en = 1; mem_rd_addr = r; mem_is_load = 1;
    cycle();
    idle_inputs();
  endtask

  typedef struct {
    logic [REG_AW-1:0] rs0, rs1;
    logic [DATA_W-1:0] rf0, rf1, imm;
    logic [1:0]        imm_sel;
    logic              mem_wr;
    logic [REG_AW-1:0] mem_rd;
    logic [DATA_W-1:0] mem_res;
    logic              wb_wr;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_dat;
    logic [DATA_W-1:0] exp0, exp1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{5, 5, 32'h1, 32'h2, 32'h10, 2'b10, 1, 5, 32'hAAAA0000, 1, 5, 32'h5555, 32'hAAAA0000, 32'h10};
    vecs[1] = '{0, 0, 32'h11, 32'h22, 32'h10, 2'b00, 1, 0, 32'hAAAA0000, 1, 0, 32'h5555, 32'h0, 32'h0};
    vecs[2] = '{3, 4, 32'h33, 32'h44, 32'h0, 2'b00, 1, 9, 32'h99, 1, 4, 32'h77, 32'h33, 32'h77};
    vecs[3] = '{6, 8, 32'h66, 32'h88, 32'h0, 2'b00, 1, 9, 32'h99, 1, 10, 32'h77, 32'h66, 32'h88};
    vecs[4] = '{6, 0, 32'h66, 32'h88, 32'hCAFE, 2'b11, 1, 6, 32'h99, 1, 6, 32'h77, 32'hCAFE, 32'hCAFE};
    vecs[5] = '{12, 12, 32'hC0, 32'hC1, 32'h0, 2'b00, 0, 12, 32'h99, 1, 12, 32'hBEEF, 32'hBEEF, 32'hBEEF};

    idle_inputs();
    m_wait = 0; m_valid = 0; m_cnt = 0;
    for (int i = 0; i < NUM_SRC; i++) begin m_src[i] = '0; m_pend[i] = 0; end

    // Reset with an instruction offered.
    rst = 1; id_valid = 1; rs_a[0] = 5'd1; rf_a[0] = 32'hFFFF;
    repeat (2) cycle();
    check("rst_exe_valid", exe_valid, 0);
    check("rst_exe_src", exe_src, '0);
    check("rst_stall", stall_cycles, 0);
    idle_inputs();
    #1 check("rst_id_ready", id_ready, 1);

    // Forwarding priority table.
    foreach (vecs[k]) begin
      idle_inputs();
      id_valid = 1;
      rs_a[0] = vecs[k].rs0; rs_a[1] = vecs[k].rs1;
      rf_a[0] = vecs[k].rf0; rf_a[1] = vecs[k].rf1;
      id_imm = vecs[k].imm; id_imm_sel = vecs[k].imm_sel;
      mem_wr_en = vecs[k].mem_wr; mem_rd_addr = vecs[k].mem_rd; mem_alu_result = vecs[k].mem_res;
      wb_wr_en = vecs[k].wb_wr; wb_rd_addr = vecs[k].wb_rd; wb_data = vecs[k].wb_dat;
      cycle();
      check($sformatf("vec%0d_valid", k), exe_valid, 1);
      check($sformatf("vec%0d_src0", k), src(0), vecs[k].exp0);
      check($sformatf("vec%0d_src1", k), src(1), vecs[k].exp1);
    end
    idle_inputs();
    cycle();

    // Load-use: three stalled cycles then load data injected.
    issue_load_use(5'd7);
    check("lu_valid_low", exe_valid, 0);
    for (int c = 0; c < 3; c++) begin
      #1 check("lu_id_ready_low", id_ready, 0);
      id_valid = 1;
      cycle();
    end
    ld_valid = 1; ld_data = 32'hDEADBEEF;
    cycle();
    check("lu_valid", exe_valid, 1);
    check("lu_src0", src(0), 32'hDEADBEEF);
    check("lu_src1", src(1), 32'h1234);
    check("lu_stall", stall_cycles, 3);
    idle_inputs();
    cycle();

    // Backpressure with a queued instruction.
    id_valid = 1; rs_a[0] = 5'd1; rs_a[1] = 5'd2; rf_a[0] = 32'hA1; rf_a[1] = 32'hA2;
    cycle();
    exe_ready = 0; rs_a[0] = 5'd3; rs_a[1] = 5'd4; rf_a[0] = 32'hB3; rf_a[1] = 32'hB4;
    for (int c = 0; c < 4; c++) begin
      #1 check("bp_id_ready_low", id_ready, 0);
      cycle();
      check("bp_hold_valid", exe_valid, 1);
      check("bp_hold_src0", src(0), 32'hA1);
      check("bp_hold_src1", src(1), 32'hA2);
    end
    exe_ready = 1;
    #1 check("bp_id_ready_high", id_ready, 1);
    cycle();
    check("bp_next_valid", exe_valid, 1);
    check("bp_next_src0", src(0), 32'hB3);
    check("bp_next_src1", src(1), 32'hB4);
    idle_inputs();
    cycle();

    // Reset in the middle of a load wait.
    issue_load_use(5'd9);
    cycle();
    rst = 1;
    cycle();
    rst = 0; ld_valid = 1; ld_data = 32'h55;
    cycle();
    check("rmid_valid", exe_valid, 0);
    check("rmid_stall", stall_cycles, 0);
    #1 check("rmid_id_ready", id_ready, 1);
    idle_inputs();

    // Stall counter saturation.
    issue_load_use(5'd11);
    repeat (20) cycle();
    check("sat_stall", stall_cycles, CNT_MAX);
    repeat (5) cycle();
    check("sat_stall_hold", stall_cycles, CNT_MAX);
    ld_valid = 1; ld_data = 32'h77;
    cycle();
    check("sat_exit_valid", exe_valid, 1);
    idle_inputs();

    // Random traffic against the model; small register range forces matches.
    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom_range(0, 59) == 0);
      id_valid       = $urandom_range(0, 3) != 0;
      exe_ready      = $urandom_range(0, 3) != 0;
      for (int i = 0; i < NUM_SRC; i++) begin
        rs_a[i] = REG_AW'($urandom_range(0, 3));
        rf_a[i] = $urandom;
      end
      id_imm         = $urandom;
      id_imm_sel     = NUM_SRC'($urandom_range(0, 3) == 0 ? $urandom : 0);
      mem_wr_en      = $urandom_range(0, 1);
      mem_rd_addr    = REG_AW'($urandom_range(0, 3));
      mem_is_load    = $urandom_range(0, 3) == 0;
      mem_alu_result = $urandom;
      wb_wr_en       = $urandom_range(0, 1);
      wb_rd_addr     = REG_AW'($urandom_range(0, 3));
      wb_data        = $urandom;
      ld_valid       = $urandom_range(0, 2) == 0;
      ld_data        = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
